wb_ram_dma_master: RTL and testbench
====================================

Name: wb_ram_dma_master

Overview:
- Wishbone initiator that moves blocks of 32-bit words between a local stream and the four FPGA RAM windows (RAM0..RAM3, 512x32 each).
- Issues single classic Wishbone cycles with per-RAM CYC selects; the slave returns a registered ACK one cycle after STB.
- Read data goes out on a valid/ready stream; write data comes in on a valid/ready stream.
- Sits beside the RAM block so fabric logic can fill and drain buffers without the ASSP.

Parameters:
- ADDRWIDTH, 11, Wishbone address width; word index within a RAM is ADR[8:0].
- DATAWIDTH, 32, data width.
- LENWIDTH, 10, length field width; legal lengths 0..512.
- TIMEOUT_CYCLES, 16, cycles to wait for ACK before aborting.

Ports:
- WBs_CLK_i  in  1  bus/fabric clock.
- WBs_RST_n_i  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_write_i  in  1  1=stream->RAM, 0=RAM->stream.
- cmd_ram_i  in  2  target RAM 0..3.
- cmd_addr_i  in  ADDRWIDTH  start word address.
- cmd_len_i  in  LENWIDTH  word count.
- WBm_ADR_o  out  ADDRWIDTH  address.
- WBm_RAM_CYC_o  out  4  one-hot cycle select (bit n = RAMn).
- WBm_STB_o  out  1  strobe.
- WBm_WE_o  out  1  write enable.
- WBm_BYTE_STB_o  out  4  byte selects; always 4'hF during a cycle, 0 otherwise.
- WBm_DAT_o  out  DATAWIDTH  write data.
- WBm_RAM0_DAT_i..WBm_RAM3_DAT_i  in  DATAWIDTH each  per-RAM read data, muxed internally by the latched RAM select.
- WBm_ACK_i  in  1  acknowledge.
- rd_data_o  out  DATAWIDTH  read stream data.
- rd_valid_o  out  1  read stream valid.
- rd_ready_i  in  1  read stream ready.
- wr_data_i  in  DATAWIDTH  write stream data.
- wr_valid_i  in  1  write stream valid.
- wr_ready_o  out  1  write stream ready.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle pulse when a command completes, including on abort.
- err_o  out  1  sticky timeout flag; cleared on the next command accept.

Behaviour:
- Reset (async, WBs_RST_n_i=0):
  - All outputs 0 except cmd_ready_o=1.
  - FSM goes to IDLE.
  - Any bus cycle is dropped immediately.
  - Held read word is discarded.
- FSM states: IDLE, FETCH, REQ, DRAIN, FIN.
- IDLE:
  - cmd_ready_o=1.
  - On accept, latch write, ram, addr, len; clear err_o.
  - len==0 -> FIN (no bus cycle).
  - write -> FETCH; read -> REQ.
- FETCH (write only):
  - wr_ready_o=1.
  - On wr_valid_i, latch wr_data_i into WBm_DAT_o -> REQ.
- REQ:
  - Assert WBm_RAM_CYC_o[ram], WBm_STB_o=1, WBm_WE_o=write, WBm_ADR_o=current addr.
  - On the edge that samples WBm_ACK_i=1:
    - read: capture the muxed RAM data into the holding register and set rd_valid_o.
    - Decrement remaining count; increment ADR[8:0] modulo 512; ADR[10:9] held.
    - remaining==0 -> FIN for a write, DRAIN for a read.
    - Otherwise: write -> FETCH; read -> stay in REQ.
  - Read stays in REQ only if the holding register is empty or is being consumed (rd_ready_i) this cycle. Otherwise drop STB and wait (CYC held) until it is free.
  - Throughput: 2 cycles/word under no backpressure. STB is held continuously, and the slave ACKs every other cycle.
- DRAIN: wait until the last read word is consumed -> FIN.
- FIN:
  - Pulse done_o, drop CYC/STB/WE -> IDLE.
  - busy_o=1 in every state except IDLE.
- Timeout:
  - Counter counts cycles with STB=1 and ACK=0; cleared on every ACK.
  - Reaching TIMEOUT_CYCLES: set err_o, drop CYC/STB, discard held read data, go to FIN (done_o pulses).
- Bus rules:
  - A stray ACK_i outside REQ is ignored.
  - WBm_DAT_o is stable for the whole write cycle.
  - cmd_* inputs are ignored while busy.
- Simultaneous events: capture of a new word and rd_ready_i consuming the old word in the same cycle is legal; the new word replaces the old one, rd_valid_o stays 1.

Decomposition:
- Shared package wb_dma_pkg holds:
  - FSM state encoding.
  - RAM_SEL to one-hot CYC constants.
  - Word-address mask 9'h1FF.
  - Default TIMEOUT_CYCLES.
- No sub-module needed; the timeout counter and read holding register stay inline.

Test Plan:
- Read RAM1, addr 0x010, len 4, RAM preloaded 0xA0..0xA3, rd_ready_i=1 -> WBm_RAM_CYC_o=4'b0010; rd_data 0xA0,0xA1,0xA2,0xA3 in order; 8 bus cycles; done_o pulses once.
- Write RAM2, addr 0x000, len 3, stream 0x11,0x22,0x33 -> RAM2[0..2]=0x11,0x22,0x33; WBm_WE_o=1 only while STB; BYTE_STB 4'hF.
- Wrap: read RAM0 addr 0x1FE len 4 -> addresses 0x1FE,0x1FF,0x000,0x001.
- Backpressure: read len 3 with rd_ready_i low for 5 cycles after the first word -> STB drops, no word lost or duplicated, data order preserved.
- Timeout: slave never ACKs -> STB high exactly 16 cycles, then err_o=1, done_o pulse, CYC=0; the next command clears err_o.
- len=0 -> done_o one cycle after accept with no CYC. Reset asserted mid-write -> CYC/STB go 0 asynchronously and cmd_ready_o=1 after release.

Source files
------------

// File: rtl/wb_dma_pkg.sv
// Shared types and constants for the Wishbone RAM DMA initiator:
// FSM encoding, RAM select decode, word-address mask and default timeout.
package wb_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_REQ,
        ST_DRAIN,
        ST_FIN
    } state_t;

    localparam logic [3:0] CYC_RAM0 = 4'b0001;
    localparam logic [3:0] CYC_RAM1 = 4'b0010;
    localparam logic [3:0] CYC_RAM2 = 4'b0100;
    localparam logic [3:0] CYC_RAM3 = 4'b1000;

    localparam logic [8:0] WORD_MASK = 9'h1FF;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    function automatic logic [3:0] ram_cyc(input logic [1:0] sel);
        case (sel)
            2'd0:    return CYC_RAM0;
            2'd1:    return CYC_RAM1;
            2'd2:    return CYC_RAM2;
            default: return CYC_RAM3;
        endcase
    endfunction

endpackage

// File: rtl/wb_ram_dma_master.sv
// Wishbone initiator moving word blocks between local valid/ready streams
// and the four 512x32 RAM windows using single classic cycles.
module wb_ram_dma_master
    import wb_dma_pkg::*;
#(
    parameter int unsigned ADDRWIDTH      = 11,
    parameter int unsigned DATAWIDTH      = 32,
    parameter int unsigned LENWIDTH       = 10,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [1:0]           cmd_ram_i,
    input  logic [ADDRWIDTH-1:0] cmd_addr_i,
    input  logic [LENWIDTH-1:0]  cmd_len_i,
    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic [3:0]           WBm_RAM_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    input  logic [DATAWIDTH-1:0] WBm_RAM0_DAT_i,
    input  logic [DATAWIDTH-1:0] WBm_RAM1_DAT_i,
    input  logic [DATAWIDTH-1:0] WBm_RAM2_DAT_i,
    input  logic [DATAWIDTH-1:0] WBm_RAM3_DAT_i,
    input  logic                 WBm_ACK_i,
    output logic [DATAWIDTH-1:0] rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    input  logic [DATAWIDTH-1:0] wr_data_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 state, state_next;
    logic                   write_q;
    logic [1:0]             ram_q;
    logic [ADDRWIDTH-1:0]   addr_q;
    logic [LENWIDTH-1:0]    remaining;
    logic [DATAWIDTH-1:0]   wdat_q;
    logic [DATAWIDTH-1:0]   rdat_q;
    logic                   rvalid_q;
    logic                   err_q;
    logic [TW-1:0]          tcnt;

    logic                   accept;
    logic                   stb;
    logic                   ack_take;
    logic                   timeout;
    logic                   last_word;
    logic [DATAWIDTH-1:0]   ram_rdata;

    always_comb begin
        unique case (ram_q)
            2'd0:    ram_rdata = WBm_RAM0_DAT_i;
            2'd1:    ram_rdata = WBm_RAM1_DAT_i;
            2'd2:    ram_rdata = WBm_RAM2_DAT_i;
            default: ram_rdata = WBm_RAM3_DAT_i;
        endcase
    end

    assign accept    = (state == ST_IDLE) && cmd_valid_i;
    // A read only strobes while the holding register can take the next word.
    assign stb       = (state == ST_REQ) && (write_q || !rvalid_q || rd_ready_i);
    assign ack_take  = stb && WBm_ACK_i;
    assign timeout   = stb && !WBm_ACK_i && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign last_word = (remaining == LENWIDTH'(1));

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) state <= ST_IDLE;
        else              state <= state_next;
    end

    always_comb begin
        state_next     = state;
        cmd_ready_o    = 1'b0;
        wr_ready_o     = 1'b0;
        busy_o         = 1'b1;
        done_o         = 1'b0;
        WBm_RAM_CYC_o  = '0;
        WBm_STB_o      = 1'b0;
        WBm_WE_o       = 1'b0;
        WBm_BYTE_STB_o = '0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    if (cmd_len_i == '0)  state_next = ST_FIN;
                    else if (cmd_write_i) state_next = ST_FETCH;
                    else                  state_next = ST_REQ;
                end
            end
            ST_FETCH: begin
                wr_ready_o = 1'b1;
                if (wr_valid_i) state_next = ST_REQ;
            end
            ST_REQ: begin
                WBm_RAM_CYC_o  = ram_cyc(ram_q);
                WBm_BYTE_STB_o = '1;
                WBm_STB_o      = stb;
                WBm_WE_o       = stb && write_q;
                if (timeout) begin
                    state_next = ST_FIN;
                end else if (ack_take) begin
                    if (last_word)    state_next = write_q ? ST_FIN : ST_DRAIN;
                    else if (write_q) state_next = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (!rvalid_q || rd_ready_i) state_next = ST_FIN;
            end
            ST_FIN: begin
                done_o     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            write_q   <= 1'b0;
            ram_q     <= '0;
            addr_q    <= '0;
            remaining <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            tcnt      <= '0;
        end else begin
            if (accept) begin
                write_q   <= cmd_write_i;
                ram_q     <= cmd_ram_i;
                addr_q    <= cmd_addr_i;
                remaining <= cmd_len_i;
                err_q     <= 1'b0;
                tcnt      <= '0;
            end
            if ((state == ST_FETCH) && wr_valid_i) wdat_q <= wr_data_i;
            if (ack_take) begin
                remaining   <= remaining - LENWIDTH'(1);
                addr_q[8:0] <= (addr_q[8:0] + 9'd1) & WORD_MASK;
                tcnt        <= '0;
            end else if (timeout) begin
                err_q <= 1'b1;
                tcnt  <= '0;
            end else if (stb) begin
                tcnt <= tcnt + TW'(1);
            end
            // Capture wins over consumption; an abort discards any held word.
            if (timeout) begin
                rvalid_q <= 1'b0;
            end else if (ack_take && !write_q) begin
                rvalid_q <= 1'b1;
                rdat_q   <= ram_rdata;
            end else if (rd_ready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign WBm_ADR_o  = addr_q;
    assign WBm_DAT_o  = wdat_q;
    assign rd_data_o  = rdat_q;
    assign rd_valid_o = rvalid_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_wb_ram_dma_master.sv
// Self-checking bench: RAM slave model with registered ACK, stream drivers,
// and an arithmetic reference model of block transfers.
module tb_wb_ram_dma_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [1:0]  cmd_ram_i;
    logic [10:0] cmd_addr_i;
    logic [9:0]  cmd_len_i;
    logic [10:0] WBm_ADR_o;
    logic [3:0]  WBm_RAM_CYC_o, WBm_BYTE_STB_o;
    logic        WBm_STB_o, WBm_WE_o, WBm_ACK_i;
    logic [31:0] WBm_DAT_o, ram0_dat, ram1_dat, ram2_dat, ram3_dat;
    logic [31:0] rd_data_o, wr_data_i;
    logic        rd_valid_o, rd_ready_i, wr_valid_i, wr_ready_o;
    logic        busy_o, done_o, err_o;

    wb_ram_dma_master #(.ADDRWIDTH(11), .DATAWIDTH(32), .LENWIDTH(10), .TIMEOUT_CYCLES(16)) dut (
        .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_ram_i(cmd_ram_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .WBm_ADR_o(WBm_ADR_o), .WBm_RAM_CYC_o(WBm_RAM_CYC_o), .WBm_STB_o(WBm_STB_o),
        .WBm_WE_o(WBm_WE_o), .WBm_BYTE_STB_o(WBm_BYTE_STB_o), .WBm_DAT_o(WBm_DAT_o),
        .WBm_RAM0_DAT_i(ram0_dat), .WBm_RAM1_DAT_i(ram1_dat),
        .WBm_RAM2_DAT_i(ram2_dat), .WBm_RAM3_DAT_i(ram3_dat),
        .WBm_ACK_i(WBm_ACK_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM slave model ----------------
    logic [31:0] mem [4][512];
    logic [31:0] ref_mem [4][512];
    logic        mem_inited;
    logic        ack_en;
    logic        pl_en;
    logic [1:0]  pl_ram;
    logic [8:0]  pl_adr;
    logic [31:0] pl_dat;

    function automatic logic [31:0] init_word(input int n, input int a);
        return 32'h9E3779B1 * (n * 512 + a + 1);
    endfunction

    assign ram0_dat = mem[0][WBm_ADR_o[8:0]];
    assign ram1_dat = mem[1][WBm_ADR_o[8:0]];
    assign ram2_dat = mem[2][WBm_ADR_o[8:0]];
    assign ram3_dat = mem[3][WBm_ADR_o[8:0]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WBm_ACK_i <= 1'b0;
            if (mem_inited !== 1'b1) begin
                for (int n = 0; n < 4; n++)
                    for (int a = 0; a < 512; a++)
                        mem[n][a] <= init_word(n, a);
                mem_inited <= 1'b1;
            end
        end else begin
            WBm_ACK_i <= ack_en && (|WBm_RAM_CYC_o) && WBm_STB_o && !WBm_ACK_i;
            if (WBm_ACK_i && WBm_STB_o && WBm_WE_o)
                for (int n = 0; n < 4; n++)
                    if (WBm_RAM_CYC_o[n]) mem[n][WBm_ADR_o[8:0]] <= WBm_DAT_o;
            if (pl_en) mem[pl_ram][pl_adr] <= pl_dat;
        end
    end

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n, stb_cycles, cyc_cycles, cyc_wait, bus_err, done_count, done_cyc, acc_cyc;
    logic        done_err;
    logic [3:0]  cyc_seen;
    logic        cur_write;
    logic [1:0]  cur_ram;
    logic [10:0] adr_log[$];
    logic [31:0] dat_log[$];
    logic [31:0] rd_log[$];
    logic [31:0] wr_src[$];
    logic [31:0] exp_wr_g[$];
    logic        wr_rand, rd_rand, bp_arm;
    int          bp_cnt;
    logic        prev_stb, prev_ack;
    logic [31:0] prev_dat;

    task automatic clear_stats();
        stb_cycles = 0; cyc_cycles = 0; cyc_wait = 0; bus_err = 0;
        done_count = 0; done_cyc = -1; acc_cyc = -1; done_err = 1'b0; cyc_seen = '0;
        adr_log.delete(); dat_log.delete(); rd_log.delete();
        prev_stb = 1'b0; prev_ack = 1'b0; prev_dat = '0;
    endtask

    // One clock: observe at negedge, then update stream/command inputs after the edge.
    task automatic step();
        logic rd_fire, wr_fire, cmd_fire;
        @(negedge clk);
        cyc_n++;
        cyc_seen |= WBm_RAM_CYC_o;
        if (|WBm_RAM_CYC_o) cyc_cycles++;
        if (done_o) begin
            done_count++;
            done_cyc = cyc_n;
            done_err = err_o;
        end
        if (WBm_STB_o) begin
            stb_cycles++;
            if (WBm_RAM_CYC_o !== (4'b0001 << cur_ram)) bus_err++;
            if (WBm_WE_o !== cur_write) bus_err++;
            if (WBm_ACK_i) begin
                adr_log.push_back(WBm_ADR_o);
                if (WBm_WE_o) dat_log.push_back(WBm_DAT_o);
            end
        end else begin
            if (WBm_WE_o !== 1'b0) bus_err++;
            if (|WBm_RAM_CYC_o) cyc_wait++;
        end
        if ((|WBm_RAM_CYC_o) && WBm_BYTE_STB_o !== 4'hF) bus_err++;
        if (!(|WBm_RAM_CYC_o) && WBm_BYTE_STB_o !== 4'h0) bus_err++;
        if (WBm_STB_o && WBm_WE_o && prev_stb && !prev_ack && WBm_DAT_o !== prev_dat) bus_err++;
        prev_stb = WBm_STB_o && WBm_WE_o;
        prev_ack = WBm_ACK_i;
        prev_dat = WBm_DAT_o;
        rd_fire  = rd_valid_o && rd_ready_i;
        wr_fire  = wr_valid_i && wr_ready_o;
        cmd_fire = cmd_valid_i && cmd_ready_o;
        if (cmd_fire) acc_cyc = cyc_n;
        if (rd_fire) begin
            rd_log.push_back(rd_data_o);
            if (bp_arm) begin
                bp_arm = 1'b0;
                bp_cnt = 5;
            end
        end
        @(posedge clk);
        #1;
        if (cmd_fire) cmd_valid_i = 1'b0;
        if (wr_fire) void'(wr_src.pop_front());
        wr_valid_i = (wr_src.size() > 0) && (!wr_rand || $urandom_range(0, 3) != 0);
        wr_data_i  = (wr_src.size() > 0) ? wr_src[0] : 32'h0;
        if (bp_cnt > 0) begin
            rd_ready_i = 1'b0;
            bp_cnt--;
        end else begin
            rd_ready_i = rd_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    endtask

    task automatic preload(input logic [1:0] r, input logic [8:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_ram = r; pl_adr = a; pl_dat = d;
        ref_mem[r][a] = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic do_cmd(input logic w, input logic [1:0] r, input logic [10:0] a, input int len);
        int budget;
        clear_stats();
        cur_write = w;
        cur_ram   = r;
        if (w && wr_src.size() == 0)
            for (int i = 0; i < len; i++) wr_src.push_back($urandom);
        exp_wr_g = w ? wr_src : '{};
        cmd_write_i = w; cmd_ram_i = r; cmd_addr_i = a; cmd_len_i = 10'(len);
        cmd_valid_i = 1'b1;
        budget = 60 * len + 40;
        for (int i = 0; i < budget && done_count == 0; i++) step();
        if (done_count == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_done_timeout: got no done, expected done within %0d cycles", budget);
        end
        step();
        if (w)
            for (int i = 0; i < len; i++) ref_mem[r][(a + i) % 512] = exp_wr_g[i];
    endtask

    function automatic logic [10:0] exp_adr(input logic [10:0] a, input int i);
        return (a & 11'h600) | 11'((a + i) % 512);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        n_checks++; if ({WBm_STB_o, WBm_WE_o, WBm_RAM_CYC_o, WBm_BYTE_STB_o} !== 10'h0) begin
            n_fail++; $display("FAIL rst_bus: got %b expected 0", {WBm_STB_o, WBm_WE_o, WBm_RAM_CYC_o, WBm_BYTE_STB_o}); end
        n_checks++; if ({rd_valid_o, wr_ready_o, done_o, err_o} !== 4'b0) begin
            n_fail++; $display("FAIL rst_flags: got %b expected 0000", {rd_valid_o, wr_ready_o, done_o, err_o}); end
        n_checks++; if (rd_data_o !== 32'h0 || WBm_DAT_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_data: got %h/%h expected 0", rd_data_o, WBm_DAT_o); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_basic();
        for (int i = 0; i < 4; i++) preload(2'd1, 9'(16 + i), 32'hA0 + i);
        rd_rand = 1'b0; wr_rand = 1'b0;
        do_cmd(1'b0, 2'd1, 11'h010, 4);
        n_checks++; if (rd_log.size() != 4) begin n_fail++; $display("FAIL rd_count: got %0d expected 4", rd_log.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rd_log[i] !== 32'hA0 + i) begin n_fail++; $display("FAIL rd_data[%0d]: got %h expected %h", i, rd_log[i], 32'hA0 + i); end
        end
        n_checks++; if (stb_cycles != 8) begin n_fail++; $display("FAIL rd_stb_cycles: got %0d expected 8", stb_cycles); end
        n_checks++; if (cyc_seen !== 4'b0010) begin n_fail++; $display("FAIL rd_cyc: got %b expected 0010", cyc_seen); end
        n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL rd_done: got %0d expected 1", done_count); end
        n_checks++; if (bus_err != 0) begin n_fail++; $display("FAIL rd_bus_rules: got %0d expected 0", bus_err); end
    endtask

    task automatic test_write_basic();
        wr_src = '{32'h11, 32'h22, 32'h33};
        do_cmd(1'b1, 2'd2, 11'h000, 3);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mem[2][i] !== 32'h11 * (i + 1)) begin n_fail++; $display("FAIL wr_mem[%0d]: got %h expected %h", i, mem[2][i], 32'h11 * (i + 1)); end
        end
        n_checks++; if (stb_cycles != 6) begin n_fail++; $display("FAIL wr_stb_cycles: got %0d expected 6", stb_cycles); end
        n_checks++; if (bus_err != 0) begin n_fail++; $display("FAIL wr_bus_rules: got %0d expected 0", bus_err); end
        n_checks++; if (cyc_seen !== 4'b0100) begin n_fail++; $display("FAIL wr_cyc: got %b expected 0100", cyc_seen); end
        n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL wr_done: got %0d expected 1", done_count); end
    endtask

    task automatic test_wrap();
        logic [10:0] exp_a [4];
        exp_a = '{11'h1FE, 11'h1FF, 11'h000, 11'h001};
        do_cmd(1'b0, 2'd0, 11'h1FE, 4);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (adr_log[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_adr[%0d]: got %h expected %h", i, adr_log[i], exp_a[i]); end
            n_checks++; if (rd_log[i] !== ref_mem[0][exp_a[i][8:0]]) begin
                n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, rd_log[i], ref_mem[0][exp_a[i][8:0]]); end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  r;
        logic [10:0] a;
        int          mism;
        r = 2'($urandom_range(0, 3));
        a = 11'($urandom_range(0, 2047));
        bp_arm = 1'b1;
        do_cmd(1'b0, r, a, 3);
        mism = 0;
        for (int i = 0; i < 3; i++) if (rd_log[i] !== ref_mem[r][(a + i) % 512]) mism++;
        n_checks++; if (rd_log.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d expected 3", rd_log.size()); end
        n_checks++; if (mism != 0) begin n_fail++; $display("FAIL bp_data: got %0d mismatching words expected 0", mism); end
        n_checks++; if (cyc_wait == 0) begin n_fail++; $display("FAIL bp_stb_drop: got %0d stalled cycles expected >0", cyc_wait); end
        n_checks++; if (adr_log.size() != 3) begin n_fail++; $display("FAIL bp_acks: got %0d expected 3", adr_log.size()); end
    endtask

    task automatic test_timeout();
        logic [10:0] a;
        a = 11'($urandom_range(0, 2047));
        ack_en = 1'b0;
        do_cmd(1'b0, 2'd3, a, 2);
        n_checks++; if (stb_cycles != 16) begin n_fail++; $display("FAIL to_stb_cycles: got %0d expected 16", stb_cycles); end
        n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL to_done: got %0d expected 1", done_count); end
        n_checks++; if (done_err !== 1'b1) begin n_fail++; $display("FAIL to_err_at_done: got %b expected 1", done_err); end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b expected 1", err_o); end
        n_checks++; if (WBm_RAM_CYC_o !== 4'b0) begin n_fail++; $display("FAIL to_cyc: got %b expected 0", WBm_RAM_CYC_o); end
        n_checks++; if (rd_log.size() != 0) begin n_fail++; $display("FAIL to_no_data: got %0d expected 0", rd_log.size()); end
        ack_en = 1'b1;
        do_cmd(1'b0, 2'd3, a, 1);
        n_checks++; if (done_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got %b expected 0", done_err); end
        n_checks++; if (rd_log[0] !== ref_mem[3][a[8:0]]) begin n_fail++; $display("FAIL to_recover: got %h expected %h", rd_log[0], ref_mem[3][a[8:0]]); end
    endtask

    task automatic test_len_zero();
        for (int w = 0; w < 2; w++) begin
            do_cmd(w[0], 2'($urandom_range(0, 3)), 11'($urandom_range(0, 2047)), 0);
            n_checks++; if (done_cyc - acc_cyc != 1) begin n_fail++; $display("FAIL len0_latency: got %0d expected 1", done_cyc - acc_cyc); end
            n_checks++; if (cyc_cycles != 0) begin n_fail++; $display("FAIL len0_no_cyc: got %0d expected 0", cyc_cycles); end
            n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL len0_done: got %0d expected 1", done_count); end
        end
    endtask

    task automatic test_back_to_back();
        logic        w;
        logic [1:0]  r;
        logic [10:0] a;
        int          len, mism_d, mism_a;
        rd_rand = 1'b1; wr_rand = 1'b1;
        for (int k = 0; k < 16; k++) begin
            w   = 1'($urandom_range(0, 1));
            r   = 2'($urandom_range(0, 3));
            a   = 11'($urandom_range(0, 2047));
            len = (k == 0) ? 512 : $urandom_range(1, 24);
            if (k == 1) w = 1'b0;
            do_cmd(w, r, a, len);
            mism_d = 0; mism_a = 0;
            for (int i = 0; i < len; i++) begin
                if (adr_log[i] !== exp_adr(a, i)) mism_a++;
                if (w) begin
                    if (mem[r][(a + i) % 512] !== ref_mem[r][(a + i) % 512]) mism_d++;
                    if (dat_log[i] !== exp_wr_g[i]) mism_d++;
                end else if (rd_log[i] !== ref_mem[r][(a + i) % 512]) begin
                    mism_d++;
                end
            end
            n_checks++; if (adr_log.size() != len) begin n_fail++; $display("FAIL rnd%0d_acks: got %0d expected %0d", k, adr_log.size(), len); end
            n_checks++; if (rd_log.size() != (w ? 0 : len)) begin n_fail++; $display("FAIL rnd%0d_rd_count: got %0d expected %0d", k, rd_log.size(), w ? 0 : len); end
            n_checks++; if (mism_a != 0) begin n_fail++; $display("FAIL rnd%0d_adr: got %0d bad addresses expected 0", k, mism_a); end
            n_checks++; if (mism_d != 0) begin n_fail++; $display("FAIL rnd%0d_data: got %0d bad words expected 0", k, mism_d); end
            n_checks++; if (bus_err != 0 || done_count != 1) begin
                n_fail++; $display("FAIL rnd%0d_bus: got bus_err=%0d done=%0d expected 0/1", k, bus_err, done_count); end
        end
        rd_rand = 1'b0; wr_rand = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic seen;
        clear_stats();
        cur_write = 1'b1; cur_ram = 2'd2;
        for (int i = 0; i < 4; i++) wr_src.push_back($urandom);
        cmd_write_i = 1'b1; cmd_ram_i = 2'd2; cmd_addr_i = 11'h040; cmd_len_i = 10'd4;
        cmd_valid_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (stb_cycles > 0) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL mw_stb_seen: got no strobe expected one within 50 cycles"); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (WBm_STB_o !== 1'b0 || WBm_RAM_CYC_o !== 4'b0) begin
            n_fail++; $display("FAIL mw_async_drop: got stb=%b cyc=%b expected 0/0000", WBm_STB_o, WBm_RAM_CYC_o); end
        cmd_valid_i = 1'b0; wr_src.delete(); wr_valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL mw_cmd_ready: got %b expected 1", cmd_ready_o); end
        n_checks++; if (busy_o !== 1'b0 || rd_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL mw_idle: got busy=%b rd_valid=%b expected 0/0", busy_o, rd_valid_o); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_ram_i = '0; cmd_addr_i = '0; cmd_len_i = '0;
        wr_valid_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b1;
        ack_en = 1'b1; pl_en = 1'b0; pl_ram = '0; pl_adr = '0; pl_dat = '0;
        wr_rand = 1'b0; rd_rand = 1'b0; bp_arm = 1'b0; bp_cnt = 0; cyc_n = 0;
        cur_write = 1'b0; cur_ram = '0;
        clear_stats();
        for (int n = 0; n < 4; n++)
            for (int a = 0; a < 512; a++)
                ref_mem[n][a] = init_word(n, a);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_read_basic();
        test_write_basic();
        test_wrap();
        test_backpressure();
        test_timeout();
        test_len_zero();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion within 2000000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
